adc_capture_ctrl: RTL and testbench

Capture sequencer between the AD4225 dual-channel ADC front end and the AXI DMA S2MM stream in the role. Software programs packet length and packet count through the user AXI-Lite window, then starts a capture; the block gates synchronized ADC samples into AXI-Stream beats, inserts `tlast` per packet, and stops after the programmed count or on abort. Overruns caused by DMA back-pressure are counted, not stalled.

---
 rtl/adc_capture_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_adc_capture_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_ctrl.sv
// Capture sequencer: gates ADC sample pairs into AXI-Stream packets for the DMA,
// with an AXI-Lite register window for length/count/start/abort and status.
module adc_capture_ctrl #(
  parameter int ADC_WIDTH  = 12,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                    sys_clk,
  input  logic                    perif_rst_n,
  input  logic                    sample_valid,
  input  logic [ADC_WIDTH-1:0]    sample_a,
  input  logic [ADC_WIDTH-1:0]    sample_b,
  input  logic [7:0]              s_axil_awaddr,
  input  logic                    s_axil_awvalid,
  output logic                    s_axil_awready,
  input  logic [31:0]             s_axil_wdata,
  input  logic                    s_axil_wvalid,
  output logic                    s_axil_wready,
  output logic [1:0]              s_axil_bresp,
  output logic                    s_axil_bvalid,
  input  logic                    s_axil_bready,
  input  logic [7:0]              s_axil_araddr,
  input  logic                    s_axil_arvalid,
  output logic                    s_axil_arready,
  output logic [31:0]             s_axil_rdata,
  output logic [1:0]              s_axil_rresp,
  output logic                    s_axil_rvalid,
  input  logic                    s_axil_rready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [5:0]              m_axis_tid,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    busy
);

  localparam int HALF = DATA_WIDTH / 2;
  localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  // register file / AXI-Lite
  logic                 awready_q, bvalid_q, arready_q, rvalid_q;
  logic [31:0]          rdata_q, rd_mux;
  logic                 cont_q, start_p_q, abort_p_q;
  logic [LEN_WIDTH-1:0] pkt_len_q, pkt_cnt_q;
  logic                 wr_en, drop_clr;
  logic [2:0]           stat_clr;

  // capture engine
  state_t               state_q;
  logic                 busy_q, fin_q;
  logic [LEN_WIDTH-1:0] len_l_q, cnt_l_q, beat_idx_q, pkt_ld_q, pkt_done_q;
  logic                 cont_l_q;
  logic                 tvalid_q, tlast_q;
  logic [DATA_WIDTH-1:0] tdata_q, beat_w;
  logic                 done_q, ovf_q, abt_q;
  logic [31:0]          drop_cnt_q;
  logic                 hs, can_load, beat_last, final_pkt, start_ok;

  logic unused_wdata;
  assign unused_wdata = &{1'b0, s_axil_wdata};

  assign s_axil_awready = awready_q;
  assign s_axil_wready  = awready_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = 2'b00;
  assign s_axil_arready = arready_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = 2'b00;

  // ready is raised for one cycle; the address/data held by the master are consumed then
  assign wr_en    = awready_q & s_axil_awvalid & s_axil_wvalid;
  assign stat_clr = (wr_en && s_axil_awaddr == 8'h0C) ? s_axil_wdata[3:1] : 3'b000;
  assign drop_clr = wr_en && s_axil_awaddr == 8'h10;

  always_comb begin
    rd_mux = '0;
    case (s_axil_araddr)
      8'h00:   rd_mux[2] = cont_q;
      8'h04:   rd_mux[LEN_WIDTH-1:0] = pkt_len_q;
      8'h08:   rd_mux[LEN_WIDTH-1:0] = pkt_cnt_q;
      8'h0C:   rd_mux[3:0] = {abt_q, ovf_q, done_q, busy_q};
      8'h10:   rd_mux = drop_cnt_q;
      8'h14:   rd_mux[LEN_WIDTH-1:0] = pkt_done_q;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge sys_clk or negedge perif_rst_n) begin
    if (!perif_rst_n) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      cont_q    <= 1'b0;
      start_p_q <= 1'b0;
      abort_p_q <= 1'b0;
      pkt_len_q <= LEN_WIDTH'(256);
      pkt_cnt_q <= ONE;
    end else begin
      awready_q <= s_axil_awvalid & s_axil_wvalid & ~awready_q & ~bvalid_q;
      if (awready_q)          bvalid_q <= 1'b1;
      else if (s_axil_bready) bvalid_q <= 1'b0;
      arready_q <= s_axil_arvalid & ~arready_q & ~rvalid_q;
      if (arready_q) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_mux;
      end else if (s_axil_rready) begin
        rvalid_q <= 1'b0;
      end
      start_p_q <= 1'b0;
      abort_p_q <= 1'b0;
      if (wr_en) begin
        case (s_axil_awaddr)
          8'h00: begin
            cont_q    <= s_axil_wdata[2];
            start_p_q <= s_axil_wdata[0] & ~s_axil_wdata[1];
            abort_p_q <= s_axil_wdata[1];
          end
          8'h04:   pkt_len_q <= s_axil_wdata[LEN_WIDTH-1:0];
          8'h08:   pkt_cnt_q <= s_axil_wdata[LEN_WIDTH-1:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    beat_w = '0;
    beat_w[ADC_WIDTH-1:0]     = sample_a;
    beat_w[HALF +: ADC_WIDTH] = sample_b;
  end

  assign hs        = tvalid_q & m_axis_tready;
  assign can_load  = ~tvalid_q | m_axis_tready;
  assign beat_last = beat_idx_q == (len_l_q - ONE);
  assign final_pkt = ~cont_l_q & (pkt_ld_q == (cnt_l_q - ONE));
  assign start_ok  = start_p_q & (pkt_len_q != '0) & (cont_q | (pkt_cnt_q != '0));

  always_ff @(posedge sys_clk or negedge perif_rst_n) begin
    if (!perif_rst_n) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      fin_q      <= 1'b0;
      len_l_q    <= '0;
      cnt_l_q    <= '0;
      cont_l_q   <= 1'b0;
      beat_idx_q <= '0;
      pkt_ld_q   <= '0;
      pkt_done_q <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tdata_q    <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      abt_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      if (hs)           tvalid_q   <= 1'b0;
      if (hs & tlast_q) pkt_done_q <= pkt_done_q + ONE;
      done_q <= done_q & ~stat_clr[0];
      ovf_q  <= ovf_q  & ~stat_clr[1];
      abt_q  <= abt_q  & ~stat_clr[2];
      if (drop_clr) drop_cnt_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            state_q    <= S_RUN;
            busy_q     <= 1'b1;
            fin_q      <= 1'b0;
            len_l_q    <= pkt_len_q;
            cnt_l_q    <= pkt_cnt_q;
            cont_l_q   <= cont_q;
            beat_idx_q <= '0;
            pkt_ld_q   <= '0;
            pkt_done_q <= '0;
          end
        end
        S_RUN: begin
          if (abort_p_q) begin
            // packet boundary with nothing left to send: no padding needed
            if (beat_idx_q == '0 && can_load) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              abt_q   <= 1'b1;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_FLUSH;
            end
          end else if (fin_q) begin
            if (hs) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else if (sample_valid) begin
            if (can_load) begin
              tvalid_q <= 1'b1;
              tdata_q  <= beat_w;
              tlast_q  <= beat_last;
              if (beat_last) begin
                beat_idx_q <= '0;
                pkt_ld_q   <= pkt_ld_q + ONE;
                if (final_pkt) fin_q <= 1'b1;
              end else begin
                beat_idx_q <= beat_idx_q + ONE;
              end
            end else begin
              if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 32'd1;
              ovf_q <= 1'b1;
            end
          end
        end
        S_FLUSH: begin
          if (can_load) begin
            if (beat_idx_q == '0) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              abt_q   <= 1'b1;
              done_q  <= 1'b1;
            end else begin
              // zero-fill the open packet so the DMA sees a complete length
              tvalid_q   <= 1'b1;
              tdata_q    <= '0;
              tlast_q    <= beat_last;
              beat_idx_q <= beat_last ? '0 : beat_idx_q + ONE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tkeep  = '1;
  assign m_axis_tid    = 6'd0;
  assign busy          = busy_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl: register table plus capture/abort/reset sequences.
module tb_adc_capture_ctrl;

  logic        sys_clk = 1'b0;
  logic        perif_rst_n;
  logic        sample_valid;
  logic [11:0] sample_a, sample_b;
  logic [7:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] wdata, rdata;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic [5:0]  tid;
  logic        tlast, tvalid, tready, busy;

  int vec_cnt = 0;
  int miscompares = 0;

  adc_capture_ctrl #(.ADC_WIDTH(12), .DATA_WIDTH(32), .LEN_WIDTH(16)) dut (
    .sys_clk(sys_clk), .perif_rst_n(perif_rst_n),
    .sample_valid(sample_valid), .sample_a(sample_a), .sample_b(sample_b),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tid(tid), .m_axis_tlast(tlast),
    .m_axis_tvalid(tvalid), .m_axis_tready(tready), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  logic [31:0] bq_data[$];
  logic        bq_last[$];
  always @(negedge sys_clk)
    if (perif_rst_n && tvalid && tready) begin
      bq_data.push_back(tdata);
      bq_last.push_back(tlast);
    end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk); #1;
  endtask

  task automatic axil_write(input logic [7:0] a, input logic [31:0] d);
    int n = 0;
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
    while (!awready && n < 20) begin tick(); n++; end
    if (!awready) chk("awready_timeout", {31'd0, awready}, 32'd1);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("bvalid_okay", {29'd0, bvalid, bresp}, {29'd0, 1'b1, 2'b00});
    tick();
  endtask

  task automatic axil_read(input logic [7:0] a, output logic [31:0] d);
    int n = 0;
    araddr = a; arvalid = 1'b1;
    while (!arready && n < 20) begin tick(); n++; end
    if (!arready) chk("arready_timeout", {31'd0, arready}, 32'd1);
    tick();
    arvalid = 1'b0;
    d = rdata;
    if (!rvalid || rresp != 2'b00) chk("rvalid_okay", {29'd0, rvalid, rresp}, {29'd0, 1'b1, 2'b00});
    tick();
  endtask

  task automatic rd_chk(input string nm, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    axil_read(a, d);
    chk(nm, d, exp);
  endtask

  task automatic strobe(input logic [11:0] a, input logic [11:0] b);
    sample_valid = 1'b1; sample_a = a; sample_b = b;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 50) begin tick(); n++; end
    chk(nm, {31'd0, busy}, 32'd0);
  endtask

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } reg_vec_t;

  reg_vec_t    tbl[15];
  logic [31:0] exp_d[8];
  logic [11:0] sa, sb;
  int          base;

  initial begin
    perif_rst_n = 1'b0;
    sample_valid = 1'b0; sample_a = '0; sample_b = '0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arvalid = 1'b0; rready = 1'b1; tready = 1'b1;

    tbl[0]  = '{1'b0, 8'h04, 32'h0,     32'h0000_0100};
    tbl[1]  = '{1'b0, 8'h08, 32'h0,     32'h0000_0001};
    tbl[2]  = '{1'b0, 8'h0C, 32'h0,     32'h0000_0000};
    tbl[3]  = '{1'b0, 8'h10, 32'h0,     32'h0000_0000};
    tbl[4]  = '{1'b0, 8'h14, 32'h0,     32'h0000_0000};
    tbl[5]  = '{1'b0, 8'h00, 32'h0,     32'h0000_0000};
    tbl[6]  = '{1'b1, 8'h04, 32'h1234,  32'h0};
    tbl[7]  = '{1'b0, 8'h04, 32'h0,     32'h0000_1234};
    tbl[8]  = '{1'b1, 8'h08, 32'hABCDE, 32'h0};
    tbl[9]  = '{1'b0, 8'h08, 32'h0,     32'h0000_BCDE};
    tbl[10] = '{1'b1, 8'h00, 32'h4,     32'h0};
    tbl[11] = '{1'b0, 8'h00, 32'h0,     32'h0000_0004};
    tbl[12] = '{1'b1, 8'h18, 32'hFFFF,  32'h0};
    tbl[13] = '{1'b0, 8'h18, 32'h0,     32'h0000_0000};
    tbl[14] = '{1'b0, 8'h0C, 32'h0,     32'h0000_0000};

    tick(); tick();
    chk("rst_tvalid", {31'd0, tvalid}, 32'd0);
    chk("rst_busy",   {31'd0, busy},   32'd0);
    perif_rst_n = 1'b1;
    tick();
    chk("tkeep_tid", {22'd0, tid, tkeep}, {22'd0, 6'd0, 4'hF});

    for (int i = 0; i < 15; i++) begin
      if (tbl[i].wr) axil_write(tbl[i].addr, tbl[i].data);
      else           rd_chk($sformatf("reg_vec%0d", i), tbl[i].addr, tbl[i].exp);
    end

    // two packets of four, stream always ready
    axil_write(8'h04, 32'd4);
    axil_write(8'h08, 32'd2);
    axil_write(8'h00, 32'h1);
    chk("t1_busy_run", {31'd0, busy}, 32'd1);
    base = bq_data.size();
    for (int i = 0; i < 8; i++) begin
      sa = 12'h0A0 + 12'(i); sb = 12'h5C0 + 12'(i);
      exp_d[i] = {4'h0, sb, 4'h0, sa};
      strobe(sa, sb);
    end
    chk("t1_busy_last_beat", {31'd0, busy}, 32'd1);
    tick();
    chk("t1_busy_after", {31'd0, busy}, 32'd0);
    tick();
    chk("t1_beat_count", bq_data.size() - base, 32'd8);
    for (int i = 0; i < 8 && base + i < bq_data.size(); i++) begin
      chk($sformatf("t1_tdata%0d", i), bq_data[base+i], exp_d[i]);
      chk($sformatf("t1_tlast%0d", i), {31'd0, bq_last[base+i]}, (i == 3 || i == 7) ? 32'd1 : 32'd0);
    end
    rd_chk("t1_status",   8'h0C, 32'h2);
    rd_chk("t1_pkt_done", 8'h14, 32'd2);
    rd_chk("t1_drop_cnt", 8'h10, 32'd0);

    // back-pressure: beat 0 held, two samples dropped
    axil_write(8'h08, 32'd1);
    axil_write(8'h00, 32'h1);
    base = bq_data.size();
    tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sa = 12'h300 + 12'(i); sb = 12'h700 + 12'(i);
      exp_d[i] = {4'h0, sb, 4'h0, sa};
      strobe(sa, sb);
    end
    chk("t2_held_valid", {31'd0, tvalid}, 32'd1);
    chk("t2_held_data",  tdata, exp_d[0]);
    tready = 1'b1;
    tick();
    for (int i = 3; i < 6; i++) begin
      sa = 12'h300 + 12'(i); sb = 12'h700 + 12'(i);
      exp_d[i] = {4'h0, sb, 4'h0, sa};
      strobe(sa, sb);
    end
    tick();
    chk("t2_busy_after", {31'd0, busy}, 32'd0);
    chk("t2_beat_count", bq_data.size() - base, 32'd4);
    if (bq_data.size() - base == 4) begin
      chk("t2_tdata0", bq_data[base],   exp_d[0]);
      chk("t2_tdata1", bq_data[base+1], exp_d[3]);
      chk("t2_tdata3", bq_data[base+3], exp_d[5]);
      chk("t2_tlast",  {28'd0, bq_last[base], bq_last[base+1], bq_last[base+2], bq_last[base+3]}, 32'h1);
    end
    rd_chk("t2_status",   8'h0C, 32'h6);
    rd_chk("t2_drop_cnt", 8'h10, 32'd2);
    rd_chk("t2_pkt_done", 8'h14, 32'd1);
    axil_write(8'h0C, 32'hE);
    rd_chk("t2_status_clr", 8'h0C, 32'h0);
    axil_write(8'h10, 32'h0);
    rd_chk("t2_drop_clr", 8'h10, 32'h0);

    // continuous mode, abort mid-packet pads with a zero tlast beat
    axil_write(8'h04, 32'd3);
    axil_write(8'h00, 32'h5);
    base = bq_data.size();
    for (int i = 0; i < 5; i++) begin
      sa = 12'h010 + 12'(i); sb = 12'h020 + 12'(i);
      exp_d[i] = {4'h0, sb, 4'h0, sa};
      strobe(sa, sb);
    end
    exp_d[5] = 32'h0;
    axil_write(8'h00, 32'h6);
    wait_idle("t3_flush_idle");
    chk("t3_beat_count", bq_data.size() - base, 32'd6);
    for (int i = 0; i < 6 && base + i < bq_data.size(); i++) begin
      chk($sformatf("t3_tdata%0d", i), bq_data[base+i], exp_d[i]);
      chk($sformatf("t3_tlast%0d", i), {31'd0, bq_last[base+i]}, (i == 2 || i == 5) ? 32'd1 : 32'd0);
    end
    rd_chk("t3_status",   8'h0C, 32'hA);
    rd_chk("t3_pkt_done", 8'h14, 32'd2);

    // illegal START, ABORT in IDLE, START while running
    axil_write(8'h0C, 32'hE);
    axil_write(8'h00, 32'h2);
    rd_chk("t4_abort_idle", 8'h0C, 32'h0);
    axil_write(8'h04, 32'd0);
    axil_write(8'h00, 32'h1);
    chk("t4_len0_busy", {31'd0, busy}, 32'd0);
    base = bq_data.size();
    strobe(12'h111, 12'h222);
    tick();
    chk("t4_len0_no_beats", bq_data.size() - base, 32'd0);
    axil_write(8'h04, 32'd4);
    axil_write(8'h00, 32'h1);
    for (int i = 0; i < 2; i++) begin
      sa = 12'h400 + 12'(i); sb = 12'h800 + 12'(i);
      exp_d[i] = {4'h0, sb, 4'h0, sa};
      strobe(sa, sb);
    end
    axil_write(8'h00, 32'h1);
    chk("t4_restart_busy", {31'd0, busy}, 32'd1);
    for (int i = 2; i < 4; i++) begin
      sa = 12'h400 + 12'(i); sb = 12'h800 + 12'(i);
      exp_d[i] = {4'h0, sb, 4'h0, sa};
      strobe(sa, sb);
    end
    tick();
    chk("t4_busy_after", {31'd0, busy}, 32'd0);
    chk("t4_beat_count", bq_data.size() - base, 32'd4);
    if (bq_data.size() - base == 4) begin
      chk("t4_tdata3", bq_data[base+3], exp_d[3]);
      chk("t4_tlast",  {28'd0, bq_last[base], bq_last[base+1], bq_last[base+2], bq_last[base+3]}, 32'h1);
    end

    // asynchronous reset while a beat is pending
    axil_write(8'h00, 32'h1);
    tready = 1'b0;
    strobe(12'hABC, 12'hDEF);
    strobe(12'h123, 12'h456);
    chk("t5_pending_valid", {31'd0, tvalid}, 32'd1);
    #2;
    perif_rst_n = 1'b0;
    #1;
    chk("t5_async_tvalid", {31'd0, tvalid}, 32'd0);
    chk("t5_async_tdata",  tdata, 32'd0);
    chk("t5_async_busy",   {30'd0, busy, tlast}, 32'd0);
    tick();
    perif_rst_n = 1'b1;
    tready = 1'b1;
    tick();
    rd_chk("t5_pkt_len",  8'h04, 32'h100);
    rd_chk("t5_pkt_cnt",  8'h08, 32'h1);
    rd_chk("t5_status",   8'h0C, 32'h0);
    rd_chk("t5_drop_cnt", 8'h10, 32'h0);
    rd_chk("t5_pkt_done", 8'h14, 32'h0);
    rd_chk("t5_unmapped", 8'h18, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
